// File: rtl/axi_pkg.sv
// ----------------------------------------------------------------------------
// axi_pkg: shared AXI4 burst, response and FSM-state definitions.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package axi_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_ID_W   = 4;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } wr_state_t;

endpackage

`default_nettype wire

// File: rtl/axi_slave_write_ctrl_if.sv
// ----------------------------------------------------------------------------
// axi_slave_write_ctrl_if: AXI4 AW/W/B channel bundle with master/slave views.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface axi_slave_write_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

endinterface

`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
// ----------------------------------------------------------------------------
// axi_burst_addr_gen: next beat address for FIXED/INCR/WRAP bursts.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [3:0]        len_i,
  input  burst_t            burst_i,
  output logic [ADDR_W-1:0] next_addr_o
);

  logic [ADDR_W-1:0] w_step;
  logic [ADDR_W-1:0] w_total;
  logic [ADDR_W-1:0] w_mask;
  logic [ADDR_W-1:0] w_incr;

  assign w_step  = ADDR_W'(1) << size_i;
  assign w_total = (ADDR_W'(len_i) + ADDR_W'(1)) << size_i;
  assign w_mask  = w_total - ADDR_W'(1);
  assign w_incr  = addr_i + w_step;

  always_comb begin
    next_addr_o = addr_i;
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_INCR:  next_addr_o = w_incr;
      // The wrap window is the burst-sized, burst-aligned block holding addr_i.
      BURST_WRAP:  next_addr_o = (addr_i & ~w_mask) | (w_incr & w_mask);
      default:     next_addr_o = addr_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/axi_slave_write_ctrl.sv
// ----------------------------------------------------------------------------
// axi_slave_write_ctrl: AXI4 write responder driving a registered word-memory port.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module axi_slave_write_ctrl
  import axi_pkg::*;
#(
  parameter int                ADDR_W    = AXI_ADDR_W,
  parameter int                DATA_W    = AXI_DATA_W,
  parameter int                ID_W      = AXI_ID_W,
  parameter logic [ADDR_W-1:0] MEM_BASE  = '0,
  parameter int                MEM_BYTES = 4096
) (
  input  logic                  clock,
  input  logic                  reset,
  axi_slave_write_ctrl_if.slave axi,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be
);

  localparam int                c_strb_w     = DATA_W / 8;
  localparam int                c_size_max   = $clog2(c_strb_w);
  localparam logic [ADDR_W-1:0] c_align_mask = ~ADDR_W'(c_strb_w - 1);
  localparam logic [ADDR_W:0]   c_win_bytes  = (ADDR_W + 1)'(MEM_BYTES);

  wr_state_t             state_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [ID_W-1:0]       bid_q;
  logic [1:0]            bresp_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [3:0]            len_q;
  logic [2:0]            size_q;
  burst_t                burst_q;
  logic [3:0]            beat_cnt_q;
  logic                  err_q;
  logic                  supp_q;
  logic                  mem_we_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  logic [c_strb_w-1:0]   mem_be_q;

  logic [ADDR_W-1:0]     w_aw_step;
  burst_t                w_aw_burst;
  logic                  w_aw_err;
  logic [ADDR_W-1:0]     w_offset;
  logic                  w_in_range;
  logic                  w_last_beat;
  logic                  w_wlast_err;
  logic                  err_d;
  logic [ADDR_W-1:0]     w_next_addr;

  // Conditions that make the whole burst unwritable, judged on the AW request.
  assign w_aw_step  = ADDR_W'(1) << axi.awsize;
  assign w_aw_burst = burst_t'(axi.awburst);
  assign w_aw_err   = (w_aw_burst == BURST_RSVD)
                    | (int'(axi.awsize) > c_size_max)
                    | ((w_aw_burst == BURST_WRAP) && !(axi.awlen inside {4'd1, 4'd3, 4'd7, 4'd15}))
                    | (|(axi.awaddr & (w_aw_step - ADDR_W'(1))));

  assign w_offset    = addr_q - MEM_BASE;
  assign w_in_range  = {1'b0, w_offset} < c_win_bytes;
  assign w_last_beat = (beat_cnt_q == len_q);
  assign w_wlast_err = axi.wlast ^ w_last_beat;
  assign err_d       = err_q | ~w_in_range | w_wlast_err;

  axi_burst_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .addr_i      (addr_q),
    .size_i      (size_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (w_next_addr)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= RESP_OKAY;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= BURST_FIXED;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      supp_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!awready_q) begin
            awready_q <= 1'b1;
          end else if (axi.awvalid) begin
            bid_q      <= axi.awid;
            addr_q     <= axi.awaddr;
            len_q      <= axi.awlen;
            size_q     <= axi.awsize;
            burst_q    <= w_aw_burst;
            beat_cnt_q <= '0;
            err_q      <= w_aw_err;
            supp_q     <= w_aw_err;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (axi.wvalid && wready_q) begin
            // wlast errors still commit in-range beats; only AW errors gate writes.
            mem_we_q    <= w_in_range & ~supp_q;
            mem_addr_q  <= addr_q & c_align_mask;
            mem_wdata_q <= axi.wdata;
            mem_be_q    <= axi.wstrb;
            addr_q      <= w_next_addr;
            beat_cnt_q  <= beat_cnt_q + 4'd1;
            err_q       <= err_d;
            if (w_last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= err_d ? RESP_SLVERR : RESP_OKAY;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (axi.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          awready_q <= 1'b0;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  assign axi.awready = awready_q;
  assign axi.wready  = wready_q;
  assign axi.bvalid  = bvalid_q;
  assign axi.bid     = bid_q;
  assign axi.bresp   = bresp_q;

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_slave_write_ctrl.sv
// ----------------------------------------------------------------------------
// tb_axi_slave_write_ctrl: table-driven bursts with a memory-write scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_axi_slave_write_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          wlast_mode;   // 0 correct, 1 early on beat 0, 2 missing on last beat
    logic [31:0] dbase;
    bit          strb_onehot;
    logic [1:0]  exp_bresp;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;

  logic        clock;
  logic        reset;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  int  checks = 0;
  int  errors = 0;
  wr_t sb[$];
  vec_t vecs[13];

  axi_slave_write_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) axi ();

  axi_slave_write_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .ID_W      (ID_W),
    .MEM_BASE  (32'h0000_0000),
    .MEM_BYTES (4096)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .axi       (axi),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic bit m_supp(input vec_t v);
    logic [31:0] step;
    step = 32'd1 << v.size;
    return (v.burst == 2'b11) || (v.size > 3'd2) ||
           (v.burst == 2'b10 && !(v.len == 4'd1 || v.len == 4'd3 || v.len == 4'd7 || v.len == 4'd15)) ||
           ((v.addr % step) != 0);
  endfunction

  function automatic logic [31:0] m_next(input vec_t v, input logic [31:0] a);
    logic [31:0] step;
    logic [31:0] total;
    logic [31:0] base;
    step  = 32'd1 << v.size;
    total = (32'(v.len) + 32'd1) * step;
    base  = a - (a % total);
    case (v.burst)
      2'b01:   return a + step;
      2'b10:   return base + ((a - base + step) % total);
      default: return a;
    endcase
  endfunction

  // Scoreboard consumer: every observed memory write must match the oldest expectation.
  always @(negedge clock) begin
    if (!reset && mem_we) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", {63'd0, mem_we}, 64'd0);
      end else begin
        wr_t e;
        e = sb.pop_front();
        chk("mem_addr", {32'd0, mem_addr}, {32'd0, e.addr});
        chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.data});
        chk("mem_be", {60'd0, mem_be}, {60'd0, e.be});
      end
    end
  end

  task automatic do_aw(input vec_t v);
    int n;
    axi.awid = v.id; axi.awaddr = v.addr; axi.awlen = v.len;
    axi.awsize = v.size; axi.awburst = v.burst; axi.awvalid = 1'b1;
    n = 0;
    while (!axi.awready && n < 20) begin @(negedge clock); n++; end
    chk("aw_wait", {63'd0, axi.awready}, 64'd1);
    @(negedge clock);
    axi.awvalid = 1'b0;
    chk("wready_latency", {63'd0, axi.wready}, 64'd1);
  endtask

  task automatic drive_beat(input vec_t v, input int b, inout logic [31:0] a);
    int n;
    bit last;
    last = (b == int'(v.len));
    axi.wvalid = 1'b1;
    axi.wdata  = v.dbase + 32'(b);
    axi.wstrb  = v.strb_onehot ? 4'(1 << b) : 4'hF;
    case (v.wlast_mode)
      1:       axi.wlast = last || (b == 0);
      2:       axi.wlast = 1'b0;
      default: axi.wlast = last;
    endcase
    n = 0;
    while (!axi.wready && n < 20) begin @(negedge clock); n++; end
    chk("w_wait", {63'd0, axi.wready}, 64'd1);
    if (!m_supp(v) && a < 32'd4096)
      sb.push_back('{addr: a & 32'hFFFF_FFFC, data: axi.wdata, be: axi.wstrb});
    a = m_next(v, a);
    @(negedge clock);
  endtask

  task automatic run_burst(input vec_t v, input int hold);
    logic [31:0] a;
    axi.bready = (hold == 0);
    do_aw(v);
    a = v.addr;
    for (int b = 0; b <= int'(v.len); b++) drive_beat(v, b, a);
    axi.wvalid = 1'b0;
    axi.wlast  = 1'b0;
    chk("bvalid_latency", {63'd0, axi.bvalid}, 64'd1);
    for (int h = 0; h < hold; h++) begin
      chk("hold_state", {60'd0, axi.bvalid, axi.awready, axi.bresp},
          {60'd0, 1'b1, 1'b0, v.exp_bresp});
      @(negedge clock);
    end
    axi.bready = 1'b1;
    chk("bid", {60'd0, axi.bid}, {60'd0, v.id});
    chk("bresp", {62'd0, axi.bresp}, {62'd0, v.exp_bresp});
    @(negedge clock);
    chk("awready_after_b", {62'd0, axi.awready, axi.bvalid}, 64'd2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        v;
    logic [31:0] a;
    bit          saw_b;
    int          n;

    vecs[0]  = '{4'h3, 32'h010, 4'd3, 3'd2, 2'b01, 0, 32'hA0, 1'b0, 2'b00};
    vecs[1]  = '{4'h5, 32'h038, 4'd3, 3'd2, 2'b10, 0, 32'hB0, 1'b0, 2'b00};
    vecs[2]  = '{4'h1, 32'h020, 4'd2, 3'd2, 2'b00, 0, 32'hC0, 1'b1, 2'b00};
    vecs[3]  = '{4'h2, 32'hFFC, 4'd1, 3'd2, 2'b01, 0, 32'hD0, 1'b0, 2'b10};
    vecs[4]  = '{4'h6, 32'h040, 4'd0, 3'd2, 2'b11, 0, 32'hE0, 1'b0, 2'b10};
    vecs[5]  = '{4'h4, 32'h040, 4'd2, 3'd2, 2'b10, 0, 32'hF0, 1'b0, 2'b10};
    vecs[6]  = '{4'h8, 32'h042, 4'd0, 3'd2, 2'b01, 0, 32'h11, 1'b0, 2'b10};
    vecs[7]  = '{4'h9, 32'h048, 4'd0, 3'd3, 2'b01, 0, 32'h22, 1'b0, 2'b10};
    vecs[8]  = '{4'hA, 32'h051, 4'd3, 3'd0, 2'b01, 0, 32'h33, 1'b0, 2'b00};
    vecs[9]  = '{4'hB, 32'h060, 4'd1, 3'd2, 2'b01, 1, 32'h44, 1'b0, 2'b10};
    vecs[10] = '{4'hC, 32'h084, 4'd7, 3'd2, 2'b10, 0, 32'h55, 1'b0, 2'b00};
    vecs[11] = '{4'hD, 32'h070, 4'd0, 3'd2, 2'b01, 2, 32'h66, 1'b0, 2'b10};
    vecs[12] = '{4'hE, 32'h006, 4'd1, 3'd1, 2'b10, 0, 32'h77, 1'b0, 2'b00};

    reset = 1'b1;
    axi.awid = '0; axi.awaddr = '0; axi.awlen = '0; axi.awsize = '0;
    axi.awburst = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b1;
    repeat (3) @(negedge clock);
    chk("reset_hs", {60'd0, axi.awready, axi.wready, axi.bvalid, mem_we}, 64'd0);
    chk("reset_b", {58'd0, axi.bid, axi.bresp}, 64'd0);
    chk("reset_mem", {28'd0, mem_addr, mem_be}, 64'd0);
    chk("reset_wdata", {32'd0, mem_wdata}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("awready_after_reset", {63'd0, axi.awready}, 64'd1);

    // W offered before any AW must be ignored.
    axi.wvalid = 1'b1; axi.wdata = 32'hDEAD; axi.wstrb = 4'hF; axi.wlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("w_before_aw", {63'd0, axi.wready}, 64'd0);
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;

    for (int i = 0; i < 13; i++) run_burst(vecs[i], 0);

    // Backpressure on B for five cycles.
    v = '{4'h7, 32'h100, 4'd0, 3'd2, 2'b01, 0, 32'h88, 1'b0, 2'b00};
    run_burst(v, 5);

    // Reset in the middle of a burst: first beat commits, no B follows.
    v = '{4'h9, 32'h200, 4'd3, 3'd2, 2'b01, 0, 32'h99, 1'b0, 2'b00};
    axi.bready = 1'b1;
    do_aw(v);
    a = v.addr;
    drive_beat(v, 0, a);
    axi.wvalid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_mid_outputs", {60'd0, axi.awready, axi.wready, axi.bvalid, mem_we}, 64'd0);
    reset = 1'b0;
    saw_b = 1'b0;
    n = 0;
    while (!axi.awready && n < 10) begin
      @(negedge clock);
      saw_b |= axi.bvalid;
      n++;
    end
    repeat (4) begin
      @(negedge clock);
      saw_b |= axi.bvalid;
    end
    chk("no_b_after_reset", {63'd0, saw_b}, 64'd0);
    chk("awready_after_mid_reset", {63'd0, axi.awready}, 64'd1);

    run_burst(vecs[0], 0);

    repeat (5) @(negedge clock);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
